// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch unit. Walks a PC through instruction memory
//               and assembles single-word and extended (opcode + EXT_WORDS
//               extension words) instructions into one-cycle output bundles.
//               Handles exception / interrupt / return-pop / jump redirects
//               with fixed priority, and a pipeline stall.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int         ADDR_W     = 32,
    parameter int         INSTR_W    = 16,
    parameter int         EXT_WORDS  = 2,
    parameter logic [3:0] EXT_OPCODE = 4'h8,
    parameter int         RESET_VEC  = 32,
    parameter int         INT_VEC    = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         exception,
    input  logic                         interrupt,
    input  logic                         pop_pc,
    input  logic [ADDR_W-1:0]            pc_pop_val,
    input  logic                         jmp,
    input  logic [ADDR_W-1:0]            pc_jmp_val,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]           imem_rdata,
    output logic                         out_valid,
    output logic [INSTR_W-1:0]           instr,
    output logic [EXT_WORDS*INSTR_W-1:0] imm,
    output logic [ADDR_W-1:0]            pc_next,
    output logic                         int_flag,
    output logic [ADDR_W-1:0]            int_ret_pc
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_cnt_w = $clog2(EXT_WORDS) + 1;
    localparam int c_imm_w = EXT_WORDS * INSTR_W;

    localparam logic [0:0] c_st_fetch = 1'b0;
    localparam logic [0:0] c_st_ext   = 1'b1;

    localparam logic [ADDR_W-1:0]  c_reset_vec = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0]  c_int_vec   = ADDR_W'(INT_VEC);
    localparam logic [ADDR_W-1:0]  c_pc_one    = ADDR_W'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(EXT_WORDS - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [INSTR_W-1:0]  r_hold;
    logic [ADDR_W-1:0]   r_start_pc;
    logic                r_out_valid;
    logic [INSTR_W-1:0]  r_instr;
    logic [c_imm_w-1:0]  r_imm;
    logic [ADDR_W-1:0]   r_pc_next;
    logic                r_int_flag;
    logic [ADDR_W-1:0]   r_int_ret_pc;

    // Next-state values
    logic [0:0]          w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [INSTR_W-1:0]  w_hold_nxt;
    logic [ADDR_W-1:0]   w_start_pc_nxt;
    logic                w_out_valid_nxt;
    logic [INSTR_W-1:0]  w_instr_nxt;
    logic [c_imm_w-1:0]  w_imm_nxt;
    logic [ADDR_W-1:0]   w_pc_next_nxt;
    logic                w_int_flag_nxt;
    logic [ADDR_W-1:0]   w_int_ret_pc_nxt;

    // Decode helpers
    logic                w_redirect;
    logic                w_take_int;
    logic [ADDR_W-1:0]   w_redirect_pc;
    logic                w_is_ext;
    logic                w_cnt_last;
    logic [ADDR_W-1:0]   w_pc_inc;

    // Any redirect wins over stall; interrupt only counts when no exception
    assign w_redirect = exception | interrupt | pop_pc | jmp;
    assign w_take_int = interrupt & ~exception;
    assign w_is_ext   = (imem_rdata[INSTR_W-1 -: 4] == EXT_OPCODE);
    assign w_cnt_last = (r_cnt == c_cnt_last);
    // Natural wrap of the adder gives modulo-2^ADDR_W PC arithmetic
    assign w_pc_inc   = r_pc + c_pc_one;

    // Redirect target, highest priority first
    always_comb begin
        w_redirect_pc = pc_jmp_val;
        if (exception) begin
            w_redirect_pc = c_reset_vec;
        end else if (interrupt) begin
            w_redirect_pc = c_int_vec;
        end else if (pop_pc) begin
            w_redirect_pc = pc_pop_val;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: redirects force FETCH, stall freezes, EXT returns after last word
    always_comb begin
        w_state_nxt = r_state;
        if (w_redirect) begin
            w_state_nxt = c_st_fetch;
        end else if (!stall) begin
            case (r_state)
                c_st_fetch: begin
                    if (w_is_ext) begin
                        w_state_nxt = c_st_ext;
                    end
                end
                c_st_ext: begin
                    if (w_cnt_last) begin
                        w_state_nxt = c_st_fetch;
                    end
                end
                default: w_state_nxt = c_st_fetch;
            endcase
        end
    end

    // Output and datapath next values; everything holds unless explicitly updated
    always_comb begin
        w_pc_nxt         = r_pc;
        w_cnt_nxt        = r_cnt;
        w_hold_nxt       = r_hold;
        w_start_pc_nxt   = r_start_pc;
        w_out_valid_nxt  = r_out_valid;
        w_instr_nxt      = r_instr;
        w_imm_nxt        = r_imm;
        w_pc_next_nxt    = r_pc_next;
        w_int_flag_nxt   = r_int_flag;
        w_int_ret_pc_nxt = r_int_ret_pc;

        if (w_redirect) begin
            // Abandon any partially assembled instruction
            w_pc_nxt        = w_redirect_pc;
            w_cnt_nxt       = '0;
            w_out_valid_nxt = 1'b0;
            w_int_flag_nxt  = w_take_int;
            if (w_take_int) begin
                // Mid-EXT, resume at the opcode so the instruction is refetched whole
                w_int_ret_pc_nxt = (r_state == c_st_ext) ? r_start_pc : r_pc;
            end
        end else if (!stall) begin
            w_int_flag_nxt = 1'b0;
            w_pc_nxt       = w_pc_inc;
            case (r_state)
                c_st_fetch: begin
                    if (w_is_ext) begin
                        w_hold_nxt      = imem_rdata;
                        w_start_pc_nxt  = r_pc;
                        w_cnt_nxt       = '0;
                        w_out_valid_nxt = 1'b0;
                    end else begin
                        w_out_valid_nxt = 1'b1;
                        w_instr_nxt     = imem_rdata;
                        w_imm_nxt       = '0;
                        w_pc_next_nxt   = w_pc_inc;
                    end
                end
                c_st_ext: begin
                    // First extension word lands in the most-significant slice
                    for (int i = 0; i < EXT_WORDS; i++) begin
                        if (r_cnt == c_cnt_w'(i)) begin
                            w_imm_nxt[(EXT_WORDS-1-i)*INSTR_W +: INSTR_W] = imem_rdata;
                        end
                    end
                    w_cnt_nxt = r_cnt + c_cnt_one;
                    if (w_cnt_last) begin
                        w_out_valid_nxt = 1'b1;
                        w_instr_nxt     = r_hold;
                        w_pc_next_nxt   = w_pc_inc;
                    end else begin
                        w_out_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_out_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= c_reset_vec;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_start_pc   <= '0;
            r_out_valid  <= 1'b0;
            r_instr      <= '0;
            r_imm        <= '0;
            r_pc_next    <= '0;
            r_int_flag   <= 1'b0;
            r_int_ret_pc <= '0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hold       <= w_hold_nxt;
            r_start_pc   <= w_start_pc_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_instr      <= w_instr_nxt;
            r_imm        <= w_imm_nxt;
            r_pc_next    <= w_pc_next_nxt;
            r_int_flag   <= w_int_flag_nxt;
            r_int_ret_pc <= w_int_ret_pc_nxt;
        end
    end

    // Fetch address is the live PC so memory data returns in the same cycle
    assign imem_addr  = r_pc;
    assign out_valid  = r_out_valid;
    assign instr      = r_instr;
    assign imm        = r_imm;
    assign pc_next    = r_pc_next;
    assign int_flag   = r_int_flag;
    assign int_ret_pc = r_int_ret_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Scoreboard bench for instr_fetch_unit (8-bit address space,
//               fully backed by a 256-word memory). Directed scenarios then
//               randomized stall / redirect / reset traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int ADDR_W    = 8;
    localparam int INSTR_W   = 16;
    localparam int EXT_WORDS = 2;
    localparam int IMM_W     = EXT_WORDS * INSTR_W;
    localparam int RESET_VEC = 32;
    localparam int INT_VEC   = 0;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                stall = 1'b0;
    logic                exception = 1'b0;
    logic                interrupt = 1'b0;
    logic                pop_pc = 1'b0;
    logic [ADDR_W-1:0]   pc_pop_val = '0;
    logic                jmp = 1'b0;
    logic [ADDR_W-1:0]   pc_jmp_val = '0;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                out_valid;
    logic [INSTR_W-1:0]  instr;
    logic [IMM_W-1:0]    imm;
    logic [ADDR_W-1:0]   pc_next;
    logic                int_flag;
    logic [ADDR_W-1:0]   int_ret_pc;

    logic [INSTR_W-1:0]  mem [0:255];
    assign imem_rdata = mem[imem_addr];

    instr_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .EXT_WORDS (EXT_WORDS),
        .EXT_OPCODE(4'h8),
        .RESET_VEC (RESET_VEC),
        .INT_VEC   (INT_VEC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .exception (exception),
        .interrupt (interrupt),
        .pop_pc    (pop_pc),
        .pc_pop_val(pc_pop_val),
        .jmp       (jmp),
        .pc_jmp_val(pc_jmp_val),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .out_valid (out_valid),
        .instr     (instr),
        .imm       (imm),
        .pc_next   (pc_next),
        .int_flag  (int_flag),
        .int_ret_pc(int_ret_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned        tag;
        logic [INSTR_W-1:0] instr;
        logic [IMM_W-1:0]   imm;
        logic [ADDR_W-1:0]  pc_next;
    } emit_t;

    typedef struct {
        int unsigned       tag;
        logic [ADDR_W-1:0] ret;
    } intr_t;

    emit_t             emit_q[$];
    intr_t             intr_q[$];
    logic [ADDR_W-1:0] addr_q[$];

    int checks = 0;
    int errors = 0;
    int unsigned edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input bit ok,
                       input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: collects fetched words into a pending instruction and
    // emits it once it holds the required number of words.
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0]  m_pc;
    logic [ADDR_W-1:0]  m_start;
    logic [INSTR_W-1:0] pend[$];

    task automatic model_edge(input logic r, input logic st, input logic ex,
                              input logic it, input logic pp, input logic [ADDR_W-1:0] ppv,
                              input logic jp, input logic [ADDR_W-1:0] jv);
        emit_t e;
        intr_t ir;
        int    need;
        if (r) begin
            m_pc = ADDR_W'(RESET_VEC);
            pend.delete();
        end else if (ex || it || pp || jp) begin
            if (!ex && it) begin
                ir.tag = edge_cnt;
                ir.ret = (pend.size() > 0) ? m_start : m_pc;
                intr_q.push_back(ir);
            end
            pend.delete();
            if (ex)      m_pc = ADDR_W'(RESET_VEC);
            else if (it) m_pc = ADDR_W'(INT_VEC);
            else if (pp) m_pc = ppv;
            else         m_pc = jv;
        end else if (!st) begin
            if (pend.size() == 0) m_start = m_pc;
            pend.push_back(mem[m_pc]);
            m_pc = m_pc + 8'd1;
            need = (pend[0][15:12] == 4'h8) ? EXT_WORDS + 1 : 1;
            if (pend.size() == need) begin
                e.tag     = edge_cnt;
                e.instr   = pend[0];
                e.imm     = '0;
                for (int k = 1; k < pend.size(); k++) begin
                    e.imm = (e.imm << INSTR_W) | IMM_W'(pend[k]);
                end
                e.pc_next = m_pc;
                emit_q.push_back(e);
                pend.delete();
            end
        end
        addr_q.push_back(m_pc);
    endtask

    task automatic step(input logic r, input logic st, input logic ex, input logic it,
                        input logic pp, input logic [ADDR_W-1:0] ppv,
                        input logic jp, input logic [ADDR_W-1:0] jv);
        reset      = r;
        stall      = st;
        exception  = ex;
        interrupt  = it;
        pop_pc     = pp;
        pc_pop_val = ppv;
        jmp        = jp;
        pc_jmp_val = jv;
        model_edge(r, st, ex, it, pp, ppv, jp, jv);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'd0, 0, 8'd0);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: compares DUT presentations against queued expectations
    // ------------------------------------------------------------------------
    logic              mon_held;
    int unsigned       mon_tag;
    emit_t             mon_e;
    intr_t             mon_i;
    logic [ADDR_W-1:0] mon_a;
    logic              last_valid = 1'b0;
    emit_t             last_e;
    logic              last_int = 1'b0;
    logic [ADDR_W-1:0] last_ret = '0;

    always @(posedge clk) begin
        #1;
        mon_tag  = edge_cnt - 1;
        mon_held = !reset && stall && !(exception || interrupt || pop_pc || jmp);

        if (addr_q.size() == 0) begin
            chk("addr_queue_underflow", 1'b0, imem_addr, 0);
        end else begin
            mon_a = addr_q.pop_front();
            chk("imem_addr", imem_addr == mon_a, imem_addr, mon_a);
        end
        chk("valid_int_exclusive", !(out_valid && int_flag), {out_valid, int_flag}, 0);

        if (reset) begin
            chk("reset_outputs",
                !out_valid && !int_flag && instr == '0 && imm == '0 &&
                pc_next == '0 && int_ret_pc == '0,
                {out_valid, int_flag, instr, imm, pc_next, int_ret_pc}, 0);
            last_valid = 1'b0;
            last_int   = 1'b0;
        end else if (mon_held) begin
            chk("stall_hold_valid", out_valid == last_valid, out_valid, last_valid);
            if (last_valid) begin
                chk("stall_hold_bundle",
                    instr == last_e.instr && imm == last_e.imm && pc_next == last_e.pc_next,
                    {instr, imm, pc_next}, {last_e.instr, last_e.imm, last_e.pc_next});
            end
            chk("stall_hold_int", int_flag == last_int, int_flag, last_int);
            if (last_int) begin
                chk("stall_hold_ret", int_ret_pc == last_ret, int_ret_pc, last_ret);
            end
        end else begin
            if (out_valid) begin
                if (emit_q.size() == 0) begin
                    chk("unexpected_emit", 1'b0, {instr, imm, pc_next}, 0);
                end else begin
                    mon_e = emit_q.pop_front();
                    chk("emit_timing", mon_e.tag == mon_tag, mon_tag, mon_e.tag);
                    chk("emit_bundle",
                        instr == mon_e.instr && imm == mon_e.imm && pc_next == mon_e.pc_next,
                        {instr, imm, pc_next}, {mon_e.instr, mon_e.imm, mon_e.pc_next});
                    last_e = mon_e;
                end
                last_valid = 1'b1;
            end else begin
                if (emit_q.size() > 0 && emit_q[0].tag == mon_tag) begin
                    mon_e = emit_q.pop_front();
                    chk("missing_emit", 1'b0, 0, {mon_e.instr, mon_e.imm, mon_e.pc_next});
                end
                last_valid = 1'b0;
            end

            if (int_flag) begin
                if (intr_q.size() == 0) begin
                    chk("unexpected_int", 1'b0, int_ret_pc, 0);
                end else begin
                    mon_i = intr_q.pop_front();
                    chk("int_timing", mon_i.tag == mon_tag, mon_tag, mon_i.tag);
                    chk("int_ret_pc", int_ret_pc == mon_i.ret, int_ret_pc, mon_i.ret);
                    last_ret = mon_i.ret;
                end
                last_int = 1'b1;
            end else begin
                if (intr_q.size() > 0 && intr_q[0].tag == mon_tag) begin
                    mon_i = intr_q.pop_front();
                    chk("missing_int", 1'b0, 0, mon_i.ret);
                end
                last_int = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [INSTR_W-1:0] w;
        for (int i = 0; i < 256; i++) begin
            w = INSTR_W'($urandom);
            if ($urandom_range(0, 2) == 0) w[15:12] = 4'h8;
            mem[i] = w;
        end
        m_pc    = '0;
        m_start = '0;

        // Reset, then a plain instruction at the reset vector
        step(1, 0, 0, 0, 0, 8'd0, 0, 8'd0);
        step(1, 0, 0, 0, 0, 8'd0, 0, 8'd0);
        mem[32] = 16'h1234;
        idle(1);
        // Stall for three cycles with the bundle on the outputs
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 8'd0, 0, 8'd0);

        // Extended instruction at the reset vector
        step(1, 0, 0, 0, 0, 8'd0, 0, 8'd0);
        mem[32] = 16'h8001;
        mem[33] = 16'hAAAA;
        mem[34] = 16'hBBBB;
        idle(3);

        // Interrupt on the last extension word of an opcode at address 40
        mem[40] = 16'h8123;
        mem[41] = 16'hCCCC;
        mem[42] = 16'hDDDD;
        step(0, 0, 0, 0, 0, 8'd0, 1, 8'd40);
        idle(2);
        step(0, 0, 0, 1, 0, 8'd0, 0, 8'd0);
        idle(1);

        // Exception and jump together under stall: exception wins
        step(0, 1, 1, 0, 0, 8'd0, 1, 8'd100);
        idle(1);

        // pop_pc beats jmp; interrupt beats pop_pc
        step(0, 0, 0, 0, 1, 8'd50, 1, 8'd60);
        step(0, 0, 0, 1, 1, 8'd50, 0, 8'd0);
        idle(1);

        // PC wrap at the top of the address space
        mem[255] = 16'h1234;
        step(0, 0, 0, 0, 0, 8'd0, 1, 8'hFF);
        idle(1);
        mem[254] = 16'h8005;
        mem[255] = 16'h1111;
        mem[0]   = 16'h2222;
        step(0, 0, 0, 0, 0, 8'd0, 1, 8'hFE);
        idle(3);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 24) == 0,
                 ADDR_W'($urandom),
                 $urandom_range(0, 19) == 0,
                 ADDR_W'($urandom));
        end
        idle(2);

        chk("emit_queue_drained", emit_q.size() == 0, emit_q.size(), 0);
        chk("int_queue_drained", intr_q.size() == 0, intr_q.size(), 0);
        chk("addr_queue_drained", addr_q.size() == 0, addr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
